// File: rtl/cpu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pipe_pkg
//   Shared definitions for the 5-stage pipeline control logic:
//   - sequencer state encodings (RUN / DBUS_WAIT / MULDIV_WAIT)
//   - stage index constants (F, D, E, M, W) used to index stall/flush vectors
//   - default data-bus timeout in cycles
// ---------------------------------------------------------------------------
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_DBUS_WAIT   = 2'd1,
    ST_MULDIV_WAIT = 2'd2
  } hz_state_e;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;

  localparam int DEFAULT_DBUS_TIMEOUT = 16;

endpackage

// File: rtl/dbus_wait_timer.sv
// ---------------------------------------------------------------------------
// dbus_wait_timer
//   Counts data-bus wait cycles and flags the terminal count.
//   Ports:
//     i_Clk, i_Rst_n  clock, async active-low reset (count -> 0)
//     i_Clear         return count to 0 (wins over i_En)
//     i_En            increment count
//     o_Expired       count == p_TIMEOUT-1
// ---------------------------------------------------------------------------
module dbus_wait_timer #(
  parameter int p_TIMEOUT = 16,
  parameter int p_TMR_W   = 5
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Clear,
  input  logic i_En,
  output logic o_Expired
);

  localparam logic [p_TMR_W-1:0] TERM_CNT = p_TMR_W'(p_TIMEOUT - 1);

  logic [p_TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_Clear)   cnt_d = '0;
    else if (i_En) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_Expired = (cnt_q == TERM_CNT);

endmodule

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//   Pipeline sequencer for the 5-stage CPU. Produces per-stage stall/flush for
//   load-use hazards, data-bus wait states (with timeout abort), multi-cycle
//   MUL/DIV and taken branches. Priority: DBus > MUL/DIV > load-use > branch,
//   except that a branch flush overrides a same-cycle load-use stall.
//   Ports:
//     i_Clk, i_Rst_n               clock, async active-low reset
//     i_RS1Addr_D/i_RS2Addr_D      decode-stage source registers
//     i_RDAddr_E, i_MemRd_E        execute-stage destination, load flag
//     i_BranchTaken_E              redirect resolved in E
//     i_MulDivStart_E/i_MulDivDone multi-cycle unit handshake
//     i_DBusReq_M/i_DBusAck        memory-stage bus handshake
//     o_Stall_F/D/E/M              hold stage register
//     o_Flush_D/E/M/W              insert bubble
//     o_DBusErr                    one-cycle pulse on bus timeout abort
//     o_StallCycles/o_FlushCount   performance counters
//   Optional feature: define HAZARD_PERF_CNT_EN to build the two 32-bit
//   performance counters; otherwise both ports are tied to 0.
// ---------------------------------------------------------------------------
module hazard_controller
  import cpu_pipe_pkg::*;
#(
  parameter int p_DBUS_TIMEOUT = DEFAULT_DBUS_TIMEOUT,
  parameter int p_TMR_W        = 5
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [4:0]  i_RS1Addr_D,
  input  logic [4:0]  i_RS2Addr_D,
  input  logic [4:0]  i_RDAddr_E,
  input  logic        i_MemRd_E,
  input  logic        i_BranchTaken_E,
  input  logic        i_MulDivStart_E,
  input  logic        i_MulDivDone,
  input  logic        i_DBusReq_M,
  input  logic        i_DBusAck,
  output logic        o_Stall_F,
  output logic        o_Stall_D,
  output logic        o_Stall_E,
  output logic        o_Stall_M,
  output logic        o_Flush_D,
  output logic        o_Flush_E,
  output logic        o_Flush_M,
  output logic        o_Flush_W,
  output logic        o_DBusErr,
  output logic [31:0] o_StallCycles,
  output logic [31:0] o_FlushCount
);

  hz_state_e state_q, state_d;

  logic [STG_M:STG_F] stall_c, stall_o;
  logic [STG_W:STG_D] flush_c, flush_o;
  logic err_c;
  logic tmr_clr, tmr_en, tmr_exp;
  logic load_use;

  dbus_wait_timer #(
    .p_TIMEOUT (p_DBUS_TIMEOUT),
    .p_TMR_W   (p_TMR_W)
  ) u_timer (
    .i_Clk     (i_Clk),
    .i_Rst_n   (i_Rst_n),
    .i_Clear   (tmr_clr),
    .i_En      (tmr_en),
    .o_Expired (tmr_exp)
  );

  // x0 never carries a real dependency, so a load into x0 never stalls.
  assign load_use = i_MemRd_E && (i_RDAddr_E != 5'd0) &&
                    ((i_RDAddr_E == i_RS1Addr_D) || (i_RDAddr_E == i_RS2Addr_D));

  always_comb begin
    state_d = state_q;
    stall_c = '0;
    flush_c = '0;
    err_c   = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (i_DBusReq_M && !i_DBusAck) begin
          stall_c          = '1;
          flush_c[STG_W]   = 1'b1;
          tmr_en           = 1'b1;   // timer idles at 0 in RUN, so this loads 1
          state_d          = ST_DBUS_WAIT;
        end else if (i_MulDivStart_E && !i_MulDivDone) begin
          stall_c[STG_F]   = 1'b1;
          stall_c[STG_D]   = 1'b1;
          stall_c[STG_E]   = 1'b1;
          flush_c[STG_M]   = 1'b1;
          state_d          = ST_MULDIV_WAIT;
        end else if (load_use && !i_BranchTaken_E) begin
          // A same-cycle branch kills the dependent D instruction anyway.
          stall_c[STG_F]   = 1'b1;
          stall_c[STG_D]   = 1'b1;
          flush_c[STG_E]   = 1'b1;
        end
      end
      ST_DBUS_WAIT: begin
        if (i_DBusAck) begin
          tmr_clr = 1'b1;
          state_d = ST_RUN;
        end else if (tmr_exp) begin
          err_c   = 1'b1;
          tmr_clr = 1'b1;
          state_d = ST_RUN;
        end else begin
          stall_c        = '1;
          flush_c[STG_W] = 1'b1;
          tmr_en         = 1'b1;
        end
      end
      ST_MULDIV_WAIT: begin
        if (i_MulDivDone) begin
          state_d = ST_RUN;
        end else begin
          stall_c[STG_F] = 1'b1;
          stall_c[STG_D] = 1'b1;
          stall_c[STG_E] = 1'b1;
          flush_c[STG_M] = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // A branch held in a stalled E is re-presented once E advances.
    if (i_BranchTaken_E && !stall_c[STG_E]) begin
      flush_c[STG_D] = 1'b1;
      flush_c[STG_E] = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  assign stall_o   = stall_c & {4{i_Rst_n}};
  assign flush_o   = flush_c & {4{i_Rst_n}};
  assign o_Stall_F = stall_o[STG_F];
  assign o_Stall_D = stall_o[STG_D];
  assign o_Stall_E = stall_o[STG_E];
  assign o_Stall_M = stall_o[STG_M];
  assign o_Flush_D = flush_o[STG_D];
  assign o_Flush_E = flush_o[STG_E];
  assign o_Flush_M = flush_o[STG_M];
  assign o_Flush_W = flush_o[STG_W];
  assign o_DBusErr = err_c & i_Rst_n;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, |stall_o};
    flush_cnt_d = flush_cnt_q + {31'd0, |flush_o};
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_StallCycles = stall_cnt_q;
  assign o_FlushCount  = flush_cnt_q;
`else
  assign o_StallCycles = 32'd0;
  assign o_FlushCount  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
//   Directed-vector bench. Each driven cycle pushes its hand-computed
//   expected output vector into a queue; a monitor on the falling edge pops
//   and compares it with the DUT, including the performance counters.
//   Expected vector layout: {err, sF, sD, sE, sM, fD, fE, fM, fW}.
// ---------------------------------------------------------------------------
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        memrd = 1'b0, br = 1'b0, mds = 1'b0, mdd = 1'b0, req = 1'b0, ack = 1'b0;
  logic        st_f, st_d, st_e, st_m, fl_d, fl_e, fl_m, fl_w, derr;
  logic [31:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  hazard_controller #(.p_DBUS_TIMEOUT(16), .p_TMR_W(5)) dut (
    .i_Clk           (clk),
    .i_Rst_n         (rst_n),
    .i_RS1Addr_D     (rs1),
    .i_RS2Addr_D     (rs2),
    .i_RDAddr_E      (rd),
    .i_MemRd_E       (memrd),
    .i_BranchTaken_E (br),
    .i_MulDivStart_E (mds),
    .i_MulDivDone    (mdd),
    .i_DBusReq_M     (req),
    .i_DBusAck       (ack),
    .o_Stall_F       (st_f),
    .o_Stall_D       (st_d),
    .o_Stall_E       (st_e),
    .o_Stall_M       (st_m),
    .o_Flush_D       (fl_d),
    .o_Flush_E       (fl_e),
    .o_Flush_M       (fl_m),
    .o_Flush_W       (fl_w),
    .o_DBusErr       (derr),
    .o_StallCycles   (stall_cycles),
    .o_FlushCount    (flush_count)
  );

  // control bundle {memrd, br, mds, mdd, req, ack}
  localparam logic [5:0] C_NO = 6'b000000;
  localparam logic [5:0] C_LD = 6'b100000;
  localparam logic [5:0] C_BR = 6'b010000;
  localparam logic [5:0] C_MS = 6'b001000;
  localparam logic [5:0] C_MD = 6'b000100;
  localparam logic [5:0] C_RQ = 6'b000010;
  localparam logic [5:0] C_AK = 6'b000001;

  localparam logic [8:0] X_NONE = 9'b0_0000_0000;
  localparam logic [8:0] X_LU   = 9'b0_1100_0100;
  localparam logic [8:0] X_DB   = 9'b0_1111_0001;
  localparam logic [8:0] X_MD   = 9'b0_1110_0010;
  localparam logic [8:0] X_BR   = 9'b0_0000_1100;
  localparam logic [8:0] X_ERR  = 9'b1_0000_0000;

  typedef struct {
    logic [8:0] exp;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur_tag = 0;
  logic [31:0] m_sc = 0, m_fc = 0;

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (test %0d): got 0x%0h, expected 0x%0h", nm, tag, act, exp);
    end
  endtask

  // Drive one cycle: inputs change 1 time unit after the rising edge.
  task automatic cyc(input logic rstv, input logic [5:0] c, input logic [4:0] a1,
                     input logic [4:0] a2, input logic [4:0] ad, input logic [8:0] x);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rstv;
    {memrd, br, mds, mdd, req, ack} = c;
    rs1 = a1; rs2 = a2; rd = ad;
    e.exp = x;
    e.tag = cur_tag;
    exp_q.push_back(e);
  endtask

  // Monitor: every driven cycle presents one output vector on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (!rst_n) begin
          m_sc = 0;
          m_fc = 0;
        end
        chk("outputs", e.tag,
            {23'd0, derr, st_f, st_d, st_e, st_m, fl_d, fl_e, fl_m, fl_w}, {23'd0, e.exp});
        chk("stall_cycles", e.tag, stall_cycles, m_sc);
        chk("flush_count", e.tag, flush_count, m_fc);
`ifdef HAZARD_PERF_CNT_EN
        if (rst_n) begin
          m_sc = m_sc + {31'd0, |e.exp[7:4]};
          m_fc = m_fc + {31'd0, |e.exp[3:0]};
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: hazard inputs active, outputs must stay low.
    cur_tag = 0;
    cyc(1'b0, C_LD | C_RQ, 5'd5, 5'd5, 5'd5, X_NONE);
    cyc(1'b0, C_NO, 5'd0, 5'd0, 5'd0, X_NONE);

    // 1: load-use on rs2 and on rs1, one bubble each
    cur_tag = 1;
    cyc(1'b1, C_LD, 5'd0, 5'd5, 5'd5, X_LU);
    cyc(1'b1, C_NO, 5'd0, 5'd5, 5'd0, X_NONE);
    cyc(1'b1, C_LD, 5'd7, 5'd3, 5'd7, X_LU);
    cyc(1'b1, C_LD, 5'd1, 5'd2, 5'd9, X_NONE);   // no register match
    cyc(1'b1, C_NO, 5'd5, 5'd5, 5'd5, X_NONE);   // match but not a load

    // 2: load into x0 never stalls
    cur_tag = 2;
    cyc(1'b1, C_LD, 5'd0, 5'd0, 5'd0, X_NONE);

    // branch alone, and branch beating a same-cycle load-use
    cur_tag = 7;
    cyc(1'b1, C_BR, 5'd0, 5'd0, 5'd0, X_BR);
    cyc(1'b1, C_BR | C_LD, 5'd5, 5'd0, 5'd5, X_BR);
    cyc(1'b1, C_NO, 5'd0, 5'd0, 5'd0, X_NONE);

    // 3: bus wait, ack after 3 cycles; then a zero-wait access
    cur_tag = 3;
    for (int i = 0; i < 3; i++) cyc(1'b1, C_RQ, 5'd0, 5'd0, 5'd0, X_DB);
    cyc(1'b1, C_RQ | C_AK, 5'd0, 5'd0, 5'd0, X_NONE);
    cyc(1'b1, C_RQ | C_AK, 5'd0, 5'd0, 5'd0, X_NONE);
    cyc(1'b1, C_NO, 5'd0, 5'd0, 5'd0, X_NONE);

    // bus wait with branch held: no flush until the ack cycle
    cur_tag = 8;
    cyc(1'b1, C_RQ | C_BR, 5'd0, 5'd0, 5'd0, X_DB);
    cyc(1'b1, C_RQ | C_BR, 5'd0, 5'd0, 5'd0, X_DB);
    cyc(1'b1, C_RQ | C_AK | C_BR, 5'd0, 5'd0, 5'd0, X_BR);
    cyc(1'b1, C_NO, 5'd0, 5'd0, 5'd0, X_NONE);

    // 4: timeout -> 15 stall cycles, error pulse, back to RUN
    cur_tag = 4;
    for (int i = 0; i < 15; i++) cyc(1'b1, C_RQ, 5'd0, 5'd0, 5'd0, X_DB);
    cyc(1'b1, C_RQ, 5'd0, 5'd0, 5'd0, X_ERR);
    cyc(1'b1, C_NO, 5'd0, 5'd0, 5'd0, X_NONE);
    cyc(1'b1, C_LD, 5'd4, 5'd0, 5'd4, X_LU);     // RUN again

    // ack arriving on the terminal cycle wins: no error
    cur_tag = 9;
    for (int i = 0; i < 15; i++) cyc(1'b1, C_RQ, 5'd0, 5'd0, 5'd0, X_DB);
    cyc(1'b1, C_RQ | C_AK, 5'd0, 5'd0, 5'd0, X_NONE);
    cyc(1'b1, C_NO, 5'd0, 5'd0, 5'd0, X_NONE);

    // 5: MUL/DIV with branch held, done 8 cycles after start
    cur_tag = 5;
    cyc(1'b1, C_MS | C_BR, 5'd0, 5'd0, 5'd0, X_MD);
    for (int i = 0; i < 7; i++) cyc(1'b1, C_BR, 5'd0, 5'd0, 5'd0, X_MD);
    cyc(1'b1, C_MD | C_BR, 5'd0, 5'd0, 5'd0, X_BR);
    cyc(1'b1, C_NO, 5'd0, 5'd0, 5'd0, X_NONE);
    cyc(1'b1, C_MS | C_MD, 5'd0, 5'd0, 5'd0, X_NONE);  // done with start: no stall

    // priority: bus wait beats MUL/DIV start
    cur_tag = 10;
    cyc(1'b1, C_RQ | C_MS, 5'd0, 5'd0, 5'd0, X_DB);
    cyc(1'b1, C_RQ | C_AK, 5'd0, 5'd0, 5'd0, X_NONE);
    cyc(1'b1, C_NO, 5'd0, 5'd0, 5'd0, X_NONE);

    // 6: reset asserted mid bus wait
    cur_tag = 6;
    for (int i = 0; i < 3; i++) cyc(1'b1, C_RQ, 5'd0, 5'd0, 5'd0, X_DB);
    cyc(1'b0, C_RQ, 5'd0, 5'd0, 5'd0, X_NONE);
    cyc(1'b0, C_RQ, 5'd0, 5'd0, 5'd0, X_NONE);
    cyc(1'b1, C_NO, 5'd0, 5'd0, 5'd0, X_NONE);
    cyc(1'b1, C_LD, 5'd6, 5'd0, 5'd6, X_LU);     // back in RUN after reset
    cyc(1'b1, C_NO, 5'd0, 5'd0, 5'd0, X_NONE);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
